// File: rtl/ps2_cmd_pkg.sv
// ps2_cmd_pkg: shared definitions for the PS/2 command parser.
// Holds the parser FSM state encoding, the command-letter encoding and
// the ASCII constants the grammar is built from.
package ps2_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PRE_SP,
        ST_DIGIT,
        ST_POST_SP
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_VEL,
        CMD_ANG,
        CMD_FIRE
    } cmd_t;

    localparam logic [7:0] CH_NUL  = 8'h00;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_A_UP = 8'h41;
    localparam logic [7:0] CH_A_LO = 8'h61;
    localparam logic [7:0] CH_V_UP = 8'h56;
    localparam logic [7:0] CH_V_LO = 8'h76;
    localparam logic [7:0] CH_F_UP = 8'h46;
    localparam logic [7:0] CH_F_LO = 8'h66;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/ps2_decimal_accumulator.sv
// ps2_decimal_accumulator: saturating decimal accumulator.
// Ports:
//   clock, resetn  - rising-edge clock, synchronous active-low reset
//   clear          - zero the accumulator (priority over digit_en)
//   digit_en       - fold digit into accumulator: acc*10 + digit
//   digit[3:0]     - decimal digit value 0..9
//   max_value[31:0]- saturation limit; acc never exceeds it
//   acc[31:0]      - registered accumulator value
module ps2_decimal_accumulator (
    input  logic        clock,
    input  logic        resetn,
    input  logic        clear,
    input  logic        digit_en,
    input  logic [3:0]  digit,
    input  logic [31:0] max_value,
    output logic [31:0] acc
);

    // 36 bits holds (2^32-1)*10+9 without overflow.
    logic [35:0] next_wide;
    logic [31:0] next_acc;

    always_comb begin
        next_wide = {4'd0, acc} * 36'd10 + {32'd0, digit};
        if (next_wide > {4'd0, max_value})
            next_acc = max_value;
        else
            next_acc = next_wide[31:0];
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (digit_en)
            acc <= next_acc;
    end

endmodule

// File: rtl/ps2_command_parser.sv
// ps2_command_parser: walks a captured 32-char keyboard line one char per
// clock and applies V<n> / A<n> / F commands.
// Ports:
//   clock, resetn      - rising-edge clock, synchronous active-low reset
//   line_content[255:0]- ASCII line, char 0 in [255:248]
//   line_ready         - level; rising edge starts a parse when idle
//   velocity, angle    - registered command values
//   fire               - one-cycle pulse on accepted F command
//   cmd_valid          - one-cycle pulse on any accepted command
//   cmd_error          - one-cycle pulse on rejected line
//   busy               - high while a line is being parsed
module ps2_command_parser
    import ps2_cmd_pkg::*;
#(
    parameter logic [31:0] VEL_MAX  = 32'd100,
    parameter logic [31:0] ANG_MAX  = 32'd90,
    parameter logic [31:0] VEL_INIT = 32'd0,
    parameter logic [31:0] ANG_INIT = 32'd45
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [255:0] line_content,
    input  logic         line_ready,
    output logic [31:0]  velocity,
    output logic [31:0]  angle,
    output logic         fire,
    output logic         cmd_valid,
    output logic         cmd_error,
    output logic         busy
);

    state_t       state_q, state_d;
    cmd_t         cmd_q, cmd_d;
    logic [255:0] line_q;
    logic         ready_q;
    logic         rise;
    logic [7:0]   ch;
    logic         at_end;

    logic         acc_clr, acc_en;
    logic [31:0]  acc, acc_max;
    logic         set_vel, set_ang, fire_d, valid_d, error_d;

    assign rise   = line_ready & ~ready_q;
    assign ch     = line_q[255:248];
    // The shift register fills with zeros, so after 32 chars have been
    // consumed the top byte reads as NUL: one test covers both end cases.
    assign at_end = (ch == CH_NUL);
    assign busy   = (state_q != ST_IDLE);
    assign acc_max = (cmd_q == CMD_ANG) ? ANG_MAX : VEL_MAX;

    ps2_decimal_accumulator u_acc (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (acc_clr),
        .digit_en (acc_en),
        .digit    (ch[3:0]),
        .max_value(acc_max),
        .acc      (acc)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        set_vel = 1'b0;
        set_ang = 1'b0;
        fire_d  = 1'b0;
        valid_d = 1'b0;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_CMD;
                    acc_clr = 1'b1;
                end
            end
            ST_CMD: begin
                if (at_end) begin
                    state_d = ST_IDLE;
                end else if (ch == CH_V_UP || ch == CH_V_LO) begin
                    cmd_d   = CMD_VEL;
                    state_d = ST_PRE_SP;
                end else if (ch == CH_A_UP || ch == CH_A_LO) begin
                    cmd_d   = CMD_ANG;
                    state_d = ST_PRE_SP;
                end else if (ch == CH_F_UP || ch == CH_F_LO) begin
                    cmd_d   = CMD_FIRE;
                    state_d = ST_POST_SP;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRE_SP: begin
                if (is_digit(ch)) begin
                    acc_en  = 1'b1;
                    state_d = ST_DIGIT;
                end else if (ch != CH_SP) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIGIT: begin
                if (at_end) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    set_vel = (cmd_q == CMD_VEL);
                    set_ang = (cmd_q == CMD_ANG);
                end else if (is_digit(ch)) begin
                    acc_en = 1'b1;
                end else if (ch == CH_SP) begin
                    state_d = ST_POST_SP;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_POST_SP: begin
                if (at_end) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    set_vel = (cmd_q == CMD_VEL);
                    set_ang = (cmd_q == CMD_ANG);
                    fire_d  = (cmd_q == CMD_FIRE);
                end else if (ch != CH_SP) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NONE;
            line_q    <= '0;
            ready_q   <= 1'b0;
            velocity  <= VEL_INIT;
            angle     <= ANG_INIT;
            fire      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            ready_q   <= line_ready;
            fire      <= fire_d;
            cmd_valid <= valid_d;
            cmd_error <= error_d;
            if (state_q == ST_IDLE) begin
                if (rise)
                    line_q <= line_content;
            end else begin
                line_q <= {line_q[247:0], 8'h00};
            end
            if (set_vel)
                velocity <= acc;
            if (set_ang)
                angle <= acc;
        end
    end

endmodule

// File: tb/tb_ps2_command_parser.sv
module tb_ps2_command_parser;

    logic         clock;
    logic         resetn;
    logic [255:0] line_content;
    logic         line_ready;
    logic [31:0]  velocity;
    logic [31:0]  angle;
    logic         fire;
    logic         cmd_valid;
    logic         cmd_error;
    logic         busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned v_edge, v_cnt, f_edge, f_cnt, e_edge, e_cnt;

    ps2_command_parser #(
        .VEL_MAX (32'd100),
        .ANG_MAX (32'd90),
        .VEL_INIT(32'd0),
        .ANG_INIT(32'd45)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .line_content(line_content),
        .line_ready  (line_ready),
        .velocity    (velocity),
        .angle       (angle),
        .fire        (fire),
        .cmd_valid   (cmd_valid),
        .cmd_error   (cmd_error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [255:0] pack(input string s);
        logic [255:0] v;
        logic [7:0]   c;
        v = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            c = (i < $unsigned(s.len())) ? s[i] : 8'h00;
            v = {v[247:0], c};
        end
        return v;
    endfunction

    // Drives a fresh rise; returns just after capture edge E0.
    task automatic start_line(input string s, input string name);
        @(negedge clock);
        line_ready = 1'b0;
        @(negedge clock);
        line_content = pack(s);
        line_ready   = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b want 1", name, busy);
        end
    endtask

    // Observes n edges after E0, recording the edge index of each pulse.
    task automatic watch(input int unsigned n, input int unsigned drop_at,
                         input int unsigned raise_at, input logic [255:0] raise_line);
        v_edge = 0; v_cnt = 0; f_edge = 0; f_cnt = 0; e_edge = 0; e_cnt = 0;
        for (int unsigned e = 1; e <= n; e++) begin
            @(posedge clock);
            #1;
            if (cmd_valid === 1'b1) begin if (v_cnt == 0) v_edge = e; v_cnt++; end
            if (fire === 1'b1)      begin if (f_cnt == 0) f_edge = e; f_cnt++; end
            if (cmd_error === 1'b1) begin if (e_cnt == 0) e_edge = e; e_cnt++; end
            if (e == drop_at) line_ready = 1'b0;
            if (e == raise_at) begin
                line_content = raise_line;
                line_ready   = 1'b1;
            end
        end
    endtask

    task automatic expect_pulses(input string name,
                                 input int unsigned ve, input int unsigned vc,
                                 input int unsigned fe, input int unsigned fc,
                                 input int unsigned ee, input int unsigned ec);
        checks++;
        if (v_edge !== ve || v_cnt !== vc || f_edge !== fe || f_cnt !== fc ||
            e_edge !== ee || e_cnt !== ec) begin
            errors++;
            $display("FAIL %s_pulses: valid@%0d x%0d fire@%0d x%0d err@%0d x%0d want valid@%0d x%0d fire@%0d x%0d err@%0d x%0d",
                     name, v_edge, v_cnt, f_edge, f_cnt, e_edge, e_cnt, ve, vc, fe, fc, ee, ec);
        end
    endtask

    task automatic expect_regs(input string name, input logic [31:0] vel, input logic [31:0] ang);
        checks++;
        if (velocity !== vel || angle !== ang || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_regs: vel %0d ang %0d busy %b want vel %0d ang %0d busy 0",
                     name, velocity, angle, busy, vel, ang);
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        line_ready   = 1'b0;
        line_content = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (velocity !== 32'd0 || angle !== 32'd45 || fire !== 1'b0 ||
            cmd_valid !== 1'b0 || cmd_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: vel %0d ang %0d fire %b valid %b err %b busy %b want 0 45 0 0 0 0",
                     velocity, angle, fire, cmd_valid, cmd_error, busy);
        end
        resetn = 1'b1;
    endtask

    task automatic test_velocity();
        start_line("V 75", "vel75");
        watch(8, 1, 0, '0);
        expect_pulses("vel75", 5, 1, 0, 0, 0, 0);
        expect_regs("vel75", 32'd75, 32'd45);
    endtask

    task automatic test_angle();
        start_line("a30  ", "ang30");
        watch(9, 1, 0, '0);
        expect_pulses("ang30", 6, 1, 0, 0, 0, 0);
        expect_regs("ang30", 32'd75, 32'd30);
        start_line("A999", "ang999");
        watch(8, 1, 0, '0);
        expect_pulses("ang999", 5, 1, 0, 0, 0, 0);
        expect_regs("ang999", 32'd75, 32'd90);
    endtask

    task automatic test_fire();
        start_line("F", "fire");
        watch(6, 1, 0, '0);
        expect_pulses("fire", 2, 1, 2, 1, 0, 0);
        expect_regs("fire", 32'd75, 32'd90);
        start_line("F3", "fire3");
        watch(6, 1, 0, '0);
        expect_pulses("fire3", 0, 0, 0, 0, 2, 1);
        expect_regs("fire3", 32'd75, 32'd90);
    endtask

    task automatic test_errors();
        start_line("V7x", "v7x");
        watch(7, 1, 0, '0);
        expect_pulses("v7x", 0, 0, 0, 0, 3, 1);
        expect_regs("v7x", 32'd75, 32'd90);
        start_line("Q", "q");
        watch(5, 1, 0, '0);
        expect_pulses("q", 0, 0, 0, 0, 1, 1);
        start_line("V", "vonly");
        watch(5, 1, 0, '0);
        expect_pulses("vonly", 0, 0, 0, 0, 2, 1);
        expect_regs("vonly", 32'd75, 32'd90);
        start_line("", "empty");
        watch(5, 1, 0, '0);
        expect_pulses("empty", 0, 0, 0, 0, 0, 0);
        expect_regs("empty", 32'd75, 32'd90);
    endtask

    task automatic test_long_busy();
        string s;
        s = "V";
        for (int unsigned i = 0; i < 31; i++) s = {s, "1"};
        // Second rise at edge 8 lands mid-parse and stays high past commit.
        start_line(s, "long");
        watch(40, 2, 8, pack("F"));
        expect_pulses("long", 33, 1, 0, 0, 0, 0);
        expect_regs("long", 32'd100, 32'd90);
        line_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_line("V 12", "rstmid");
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetn     = 1'b0;
        line_ready = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (velocity !== 32'd0 || angle !== 32'd45 || busy !== 1'b0 ||
            fire !== 1'b0 || cmd_valid !== 1'b0 || cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: vel %0d ang %0d busy %b fire %b valid %b err %b want 0 45 0 0 0 0",
                     velocity, angle, busy, fire, cmd_valid, cmd_error);
        end
        resetn = 1'b1;
        watch(6, 0, 0, '0);
        expect_pulses("rstmid_quiet", 0, 0, 0, 0, 0, 0);
        expect_regs("rstmid_quiet", 32'd0, 32'd45);
        start_line("V 12", "after_rst");
        watch(8, 1, 0, '0);
        expect_pulses("after_rst", 5, 1, 0, 0, 0, 0);
        expect_regs("after_rst", 32'd12, 32'd45);
    endtask

    initial begin
        test_reset();
        test_velocity();
        test_angle();
        test_fire();
        test_errors();
        test_long_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
